// File: rtl/scan_pkg.sv
// Shared state encoding and default parameters for the scan sequencer.
package scan_pkg;

  localparam int SEL_W_DEF   = 3;
  localparam int DWELL_W_DEF = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/decoder3x8.sv
// One-hot 3-to-8 decoder with enable, driven by the scan sequencer.
module decoder3x8 (
  input  logic [2:0] n,
  input  logic       en,
  output logic [7:0] d
);

  always_comb begin
    d = 8'h00;
    if (en) begin
      d[n] = 1'b1;
    end
  end

endmodule

// File: rtl/dwell_counter.sv
// Loadable down-counter that times how long each select index is held.
module dwell_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Steps a select code through 0..max, holding each index dwell+1 cycles,
// in continuous or single-sweep mode.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int SEL_W   = SEL_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               ena,
  output logic               busy,
  output logic               wrap,
  output logic               done
);

  localparam logic [SEL_W-1:0] SEL_MAX = '1;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;

  dwell_counter #(.W(DWELL_W)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (dwell),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    mode_d   = mode_q;
    wrap_d   = 1'b0;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      S_IDLE: begin
        sel_d = '0;
        if (start && !stop) begin
          state_d  = S_RUN;
          mode_d   = mode;
          cnt_load = 1'b1;
        end
      end
      S_RUN: begin
        // stop outranks every index transition
        if (stop) begin
          state_d = S_IDLE;
          sel_d   = '0;
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (sel_q != SEL_MAX) begin
          sel_d    = sel_q + 1'b1;
          cnt_load = 1'b1;
        end else if (!mode_q) begin
          sel_d    = '0;
          wrap_d   = 1'b1;
          cnt_load = 1'b1;
        end else begin
          state_d = S_IDLE;
          sel_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      mode_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign sel  = sel_q;
  assign ena  = (state_q == S_RUN);
  assign busy = (state_q == S_RUN);
  assign wrap = wrap_q;
  assign done = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer with a queue-based reference model
// and a 3-to-8 decoder on the select outputs.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] dwell = 4'd0;
  logic [2:0] sel;
  logic       ena, busy, wrap, done;
  logic [7:0] d;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scan_sequencer #(.SEL_W(3), .DWELL_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .dwell (dwell),
    .sel   (sel),
    .ena   (ena),
    .busy  (busy),
    .wrap  (wrap),
    .done  (done)
  );

  decoder3x8 u_dec (
    .n  (sel),
    .en (ena),
    .d  (d)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference model: each index entry enqueues dwell+1 expected cycles.
  typedef struct {
    int sel;
    bit wrap;
  } slot_t;

  slot_t q[$];
  bit    m_run = 0;
  bit    m_single = 0;
  int    m_idx = 0;
  int    e_sel = 0;
  bit    e_ena = 0, e_busy = 0, e_wrap = 0, e_done = 0;

  function automatic void set_idle();
    e_sel  = 0;
    e_ena  = 0;
    e_busy = 0;
    e_wrap = 0;
    e_done = 0;
  endfunction

  function automatic void enter(input int idx, input bit w, input int dw);
    for (int i = 0; i <= dw; i++) begin
      q.push_back('{sel: idx, wrap: (w && i == 0)});
    end
  endfunction

  function automatic void take();
    slot_t s;
    s      = q.pop_front();
    e_sel  = s.sel;
    e_wrap = s.wrap;
    e_ena  = 1;
    e_busy = 1;
    e_done = 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0;
      q.delete();
      set_idle();
    end else if (!m_run) begin
      set_idle();
      if (start && !stop) begin
        m_run    = 1;
        m_single = mode;
        m_idx    = 0;
        enter(0, 0, int'(dwell));
        take();
      end
    end else if (stop) begin
      m_run = 0;
      q.delete();
      set_idle();
    end else begin
      if (q.size() == 0) begin
        if (m_idx < 7) begin
          m_idx++;
          enter(m_idx, 0, int'(dwell));
        end else if (!m_single) begin
          m_idx = 0;
          enter(0, 1, int'(dwell));
        end else begin
          m_run = 0;
          set_idle();
          e_done = 1;
        end
      end
      if (m_run) take();
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_sel", sel, e_sel);
      chk("m_ena", ena, e_ena);
      chk("m_busy", busy, e_busy);
      chk("m_wrap", wrap, e_wrap);
      chk("m_done", done, e_done);
      if (ena) begin
        chk("dec_onehot", $countones(d), 1);
        chk("dec_bit", d[sel], 1);
      end else begin
        chk("dec_off", d, 0);
      end
    end
  end

  task automatic go(input logic m, input logic [3:0] dw);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    dwell = dw;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_sel(input int v);
    bit found = 0;
    for (int i = 0; i < 200; i++) begin
      if (!found) begin
        @(negedge clk);
        if (int'(sel) == v && ena) found = 1;
      end
    end
    chk("wait_sel", found, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int wraps;
    int dones;
    int prev;
    bit got;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_sel", sel, 0);
    chk("rst_ena", ena, 0);
    chk("rst_busy", busy, 0);

    // Single sweep, dwell 0
    go(1'b1, 4'd0);
    chk("s1_sel0", sel, 0);
    chk("s1_ena0", ena, 1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("s1_sel", sel, i);
      chk("s1_ena", ena, 1);
      chk("s1_done_early", done, 0);
    end
    @(negedge clk);
    chk("s1_done", done, 1);
    chk("s1_end_sel", sel, 0);
    chk("s1_end_ena", ena, 0);
    chk("s1_end_busy", busy, 0);
    @(negedge clk);
    chk("s1_done_once", done, 0);

    // Continuous, dwell 2, three sweeps
    go(1'b0, 4'd2);
    wraps = 0;
    dones = 0;
    prev  = int'(sel);
    for (int i = 1; i <= 72; i++) begin
      @(negedge clk);
      if (i % 3 == 0 || i == 1) chk("s2_hold", sel, (i / 3) % 8);
      if (wrap) begin
        wraps++;
        chk("s2_wrap_prev", prev, 7);
        chk("s2_wrap_sel", sel, 0);
      end
      if (done) dones++;
      prev = int'(sel);
    end
    chk("s2_wraps", wraps, 3);
    chk("s2_dones", dones, 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

    // Stop at sel=4
    go(1'b0, 4'd0);
    wait_sel(4);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("s3_sel", sel, 0);
    chk("s3_ena", ena, 0);
    chk("s3_busy", busy, 0);
    chk("s3_wrap", wrap, 0);
    chk("s3_done", done, 0);
    @(negedge clk);
    chk("s3_stay", busy, 0);

    // Async reset at sel=5, dwell changed mid-scan
    go(1'b0, 4'd1);
    dwell = 4'd3;
    wait_sel(5);
    #2 rst = 1'b1;
    #1;
    chk("s4_sel", sel, 0);
    chk("s4_ena", ena, 0);
    chk("s4_busy", busy, 0);
    chk("s4_wrap", wrap, 0);
    chk("s4_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("s4_wait", busy, 0);
    go(1'b1, 4'd0);
    chk("s4_restart_sel", sel, 0);
    chk("s4_restart_ena", ena, 1);
    repeat (10) @(negedge clk);

    // start with stop in IDLE; start during RUN
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("s5_idle", busy, 0);
    go(1'b1, 4'd0);
    wait_sel(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("s5_sel4", sel, 4);
    chk("s5_busy", busy, 1);
    repeat (6) @(negedge clk);

    // Long dwell single sweep
    go(1'b1, 4'd15);
    chk("s6_ena0", ena, 1);
    n   = 0;
    got = 0;
    for (int i = 0; i < 300; i++) begin
      if (!got) begin
        @(negedge clk);
        n++;
        if (done) got = 1;
      end
    end
    chk("s6_seen", got, 1);
    chk("s6_cycles", n, 128);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter SEL_W, default 3: width of the select output; the scan range is 0 .. 2^SEL_W-1.
REQ-002 Parameter DWELL_W, default 4: width of the dwell input.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  level sampled on the clock edge; begins a scan from IDLE.
REQ-006 stop  input  1  level sampled on the clock edge; aborts the scan and returns to IDLE.
REQ-007 mode  input  1  0 = continuous scan, 1 = single sweep; sampled only on the start edge.
REQ-008 dwell  input  DWELL_W  cycles per index minus 1; sampled when each index is entered.
REQ-009 sel  output  SEL_W  registered select code; drives the downstream decoder n[] input.
REQ-010 ena  output  1  registered enable; drives the downstream decoder enable input.
REQ-011 busy  output  1  high in the RUN state.
REQ-012 wrap  output  1  one-cycle pulse on the cycle sel changes from max back to 0 (continuous mode only).
REQ-013 done  output  1  one-cycle pulse on the cycle a single sweep finishes.

Function
REQ-014 The block SHALL implement two states: IDLE and RUN.
REQ-015 IDLE: sel=0, ena=0, busy=0.
REQ-016 IDLE->RUN when start=1 and stop=0: on the next cycle sel=0, ena=1, busy=1; mode and dwell are latched.
REQ-017 RUN: the block SHALL hold each sel value for exactly dwell+1 cycles, using an internal dwell counter loaded with dwell on index entry and decremented each cycle.
REQ-018 When the counter reaches 0 and sel<max, sel SHALL increment by 1 on the next cycle.
REQ-019 When the counter reaches 0 and sel=max in continuous mode, sel SHALL wrap to 0 with wrap=1 for that cycle; the block stays in RUN.
REQ-020 When the counter reaches 0 and sel=max in single-sweep mode, the block SHALL go to IDLE with done=1 for one cycle; sel=0 and ena=0 in that same cycle.
REQ-021 stop=1 in RUN SHALL force IDLE on the next cycle, with sel=0, ena=0, and no done or wrap pulse; stop has priority over every other transition.
REQ-022 start=1 in RUN SHALL be ignored, with no restart.
REQ-023 start=1 and stop=1 together in IDLE: the block SHALL remain in IDLE.
REQ-024 dwell=0 SHALL advance sel every cycle, with no stall cycles.
REQ-025 ena SHALL never be 1 while sel holds a value it did not hold in the previous cycle's RUN sequence; outputs are glitch-free and all are registered.
REQ-026 In continuous mode, a dwell change mid-scan SHALL take effect at the next index entry only.

Reset
REQ-027 rst=1 SHALL asynchronously force IDLE, sel=0, ena=0, busy=0, wrap=0, done=0, and the dwell counter to 0, regardless of clk.
REQ-028 Reset asserted mid-RUN SHALL abort the scan with no done pulse; after release, the block SHALL wait for a new start.

Structure
REQ-029 State encodings (IDLE, RUN) and default parameter values SHALL live in a shared include/package, scan_pkg.
REQ-030 The dwell counter (load, decrement, zero flag) SHALL be a sub-module named dwell_counter; all other logic lives in scan_sequencer.
REQ-031 Target size: 120-400 RTL lines. No combinational path from inputs to outputs.

Verification
REQ-032 The bench SHALL instantiate scan_sequencer driving decoder3x8 and check that exactly one bit of d is high whenever ena=1.
REQ-033 Scenario 1: mode=1, dwell=0, start pulse -> sel 0,1,...,7 on consecutive cycles with ena=1; done=1 one cycle after sel=7; then sel=0, ena=0, busy=0.
REQ-034 Scenario 2: mode=0, dwell=2 -> each sel held 3 cycles; wrap=1 exactly on the 7->0 transition; no done pulse across 3 full sweeps.
REQ-035 Scenario 3: stop asserted while sel=4 -> next cycle sel=0, ena=0, busy=0; no done or wrap pulse.
REQ-036 Scenario 4: rst asserted between clock edges while sel=5 -> outputs reach their reset values before the next edge; a start after release restarts the scan at sel=0.
REQ-037 Scenario 5: start and stop both high in IDLE -> stays IDLE; start during RUN at sel=3 -> sequence continues to 4 unchanged.
REQ-038 Scenario 6: dwell=15, mode=1 -> 16 cycles per index; 128 cycles from the first ena=1 to the done pulse.
